// File: rtl/pwm_servo_pkg.sv
// Shared constants and types for the servo PWM generator and capture blocks.
// Optional build macro: PWM_GLITCH_FILTER_EN (used by pwm_capture_ch).
package pwm_servo_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COORD_MAX = 1023;

    // High time in clk cycles mapping to coordinate 0 and COORD_MAX.
    localparam int unsigned DC_MIN = 25_000;
    localparam int unsigned DC_MAX = 125_000;

    typedef enum logic [1:0] {
        StWaitRise = 2'd0,
        StMeasHigh = 2'd1,
        StMeasLow  = 2'd2
    } cap_state_e;

    // Cycles without an edge before a channel is declared dead.
    function automatic int unsigned timeout_cycles(input int unsigned periods,
                                                   input int unsigned freq,
                                                   input int unsigned target_freq);
        longint unsigned cyc;
        cyc = longint'(periods) * longint'(freq) / longint'(target_freq);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchronizer, optional glitch filter, edge detect,
// width-measurement FSM, width-to-coordinate mapper and idle timeout.
// Optional build macro: PWM_GLITCH_FILTER_EN enables the level-stability filter.
module pwm_capture_ch
    import pwm_servo_pkg::*;
#(
    parameter int unsigned MIN_DC        = DC_MIN,
    parameter int unsigned MAX_DC        = DC_MAX,
    parameter int unsigned TIMEOUT_CYC   = 5_000_000,
    parameter int unsigned GLITCH_CYCLES = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm,
    output logic [COORD_W-1:0] coord,
    output logic               valid,
    output logic               fault
);

    localparam int unsigned PW       = CNT_W + 10;
    localparam int unsigned RangeCyc = MAX_DC - MIN_DC;
    localparam logic [CNT_W-1:0] MinCnt     = CNT_W'(MIN_DC);
    localparam logic [CNT_W-1:0] MaxCnt     = CNT_W'(MAX_DC);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    logic       sync1_q, sync2_q;
    logic [1:0] warm_q;   // marks when sync2_q carries a real sample after reset
    logic       level, prev_q, rise, fall;

    // Two-flop synchronizer plus warm-up tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            warm_q  <= 2'b00;
        end else begin
            sync1_q <= pwm;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int unsigned GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GW-1:0] StabLast = GW'(GLITCH_CYCLES - 1);

    logic          level_q;
    logic [GW-1:0] stab_cnt_q;

    // Accept a new level only after it has persisted for GLITCH_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= 1'b0;
            stab_cnt_q <= '0;
        end else if (sync2_q == level_q) begin
            stab_cnt_q <= '0;
        end else if (stab_cnt_q == StabLast) begin
            level_q    <= sync2_q;
            stab_cnt_q <= '0;
        end else begin
            stab_cnt_q <= stab_cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^GLITCH_CYCLES;
    assign level         = sync2_q;
`endif

    // Previous conditioned level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= level;
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    cap_state_e         state_q, state_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   width_cnt_q, width_cnt_d, width_inc;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]   meas_q, meas_d;
    logic               map_go_q, map_go_d;
    logic               low_now, timeout;
    logic [COORD_W-1:0] coord_q, map_val;
    logic               valid_q, fault_q;
    logic [PW-1:0]      num;

    // Both the raw synced sample and the filtered level must be low to arm.
    assign low_now   = ~level & ~sync2_q;
    assign width_inc = (width_cnt_q == '1) ? width_cnt_q : width_cnt_q + CntOne;

    // Idle counter and timeout; an edge on the timeout cycle suppresses the fault.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (rise || fall)            idle_cnt_d = '0;
        else if (idle_cnt_q != '1)   idle_cnt_d = idle_cnt_q + CntOne;
        timeout = !(rise || fall) && (idle_cnt_d == TimeoutCnt);
    end

    // Measurement FSM next state.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        width_cnt_d = width_cnt_q;
        meas_d      = meas_q;
        map_go_d    = 1'b0;
        unique case (state_q)
            StWaitRise: begin
                if (warm_q[1] && low_now) armed_d = 1'b1;
                if (rise && armed_q) begin
                    state_d     = StMeasHigh;
                    width_cnt_d = CntOne;
                end
            end
            StMeasHigh: begin
                if (fall) begin
                    meas_d   = width_cnt_q;
                    map_go_d = 1'b1;
                    state_d  = StMeasLow;
                end else begin
                    width_cnt_d = width_inc;
                end
            end
            StMeasLow: begin
                if (rise) begin
                    state_d     = StMeasHigh;
                    width_cnt_d = CntOne;
                end
            end
            default: state_d = StWaitRise;
        endcase
        if (timeout) begin
            state_d = StWaitRise;
            armed_d = low_now;
        end
    end

    // Measurement state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitRise;
            armed_q     <= 1'b0;
            width_cnt_q <= '0;
            idle_cnt_q  <= '0;
            meas_q      <= '0;
            map_go_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            width_cnt_q <= width_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            meas_q      <= meas_d;
            map_go_q    <= map_go_d;
        end
    end

    // Width to coordinate, clamped at both ends and rounded to nearest.
    always_comb begin
        num     = '0;
        map_val = '0;
        if (meas_q <= MinCnt) begin
            map_val = '0;
        end else if (meas_q >= MaxCnt) begin
            map_val = COORD_W'(COORD_MAX);
        end else begin
            num     = PW'(meas_q - MinCnt) * PW'(COORD_MAX) + PW'(RangeCyc / 2);
            map_val = COORD_W'(num / PW'(RangeCyc));
        end
    end

    // Registered coordinate, strobe and fault level.
    always_ff @(posedge clk) begin
        if (rst) begin
            coord_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= map_go_q;
            if (map_go_q) begin
                coord_q <= map_val;
                fault_q <= 1'b0;
            end else if (timeout) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign coord = coord_q;
    assign valid = valid_q;
    assign fault = fault_q;

endmodule

// File: rtl/pwm_servo_capture.sv
// Three-channel servo PWM pulse-width decoder with per-channel timeout.
// Optional build macro: PWM_GLITCH_FILTER_EN (glitch filter in each channel).
module pwm_servo_capture
    import pwm_servo_pkg::*;
#(
    parameter int unsigned FREQ            = 25_000_000,
    parameter int unsigned TARGET_FREQ     = 10,
    parameter int unsigned MIN_DC          = DC_MIN,
    parameter int unsigned MAX_DC          = DC_MAX,
    parameter int unsigned TIMEOUT_PERIODS = 2,
    parameter int unsigned GLITCH_CYCLES   = 16,
    parameter int unsigned CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_servo1,
    input  logic               pwm_servo2,
    input  logic               pwm_servo3,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] z,
    output logic [2:0]         valid,
    output logic [2:0]         fault
);

    localparam int unsigned TimeoutCyc = timeout_cycles(TIMEOUT_PERIODS, FREQ, TARGET_FREQ);

    logic [2:0]         pwm_in;
    logic [COORD_W-1:0] coord [3];

    assign pwm_in = {pwm_servo3, pwm_servo2, pwm_servo1};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        pwm_capture_ch #(
            .MIN_DC        (MIN_DC),
            .MAX_DC        (MAX_DC),
            .TIMEOUT_CYC   (TimeoutCyc),
            .GLITCH_CYCLES (GLITCH_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .pwm   (pwm_in[i]),
            .coord (coord[i]),
            .valid (valid[i]),
            .fault (fault[i])
        );
    end

    assign x = coord[0];
    assign y = coord[1];
    assign z = coord[2];

endmodule

// File: tb/tb_pwm_servo_capture.sv
// Scoreboard bench for pwm_servo_capture, run with scaled-down timing parameters.
`timescale 1ns/1ps
module tb_pwm_servo_capture;

    localparam int FREQ = 1500, TFREQ = 10, MIN = 25, MAX = 125, TOP = 2, G = 8, CW = 16;
    localparam int T = TOP * FREQ / TFREQ;  // idle cycles before fault
`ifdef PWM_GLITCH_FILTER_EN
    localparam int FILT = G;
`else
    localparam int FILT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pwm = 3'b000;
    logic [9:0] x, y, z;
    logic [2:0] valid, fault;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_servo_capture #(
        .FREQ            (FREQ),
        .TARGET_FREQ     (TFREQ),
        .MIN_DC          (MIN),
        .MAX_DC          (MAX),
        .TIMEOUT_PERIODS (TOP),
        .GLITCH_CYCLES   (G),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_servo1 (pwm[0]),
        .pwm_servo2 (pwm[1]),
        .pwm_servo3 (pwm[2]),
        .x          (x),
        .y          (y),
        .z          (z),
        .valid      (valid),
        .fault      (fault)
    );

    typedef struct { int ch; int coord; int at; } exp_t;
    exp_t sb_q[$];
    exp_t flt_q[$];

    int checks = 0, errors = 0;

    // Behavioural model state
    bit         armed_m [3];
    bit         meas_m [3];
    int         hi_start [3];
    int         last_edge [3];
    int         saved_edge [3];
    bit         fault_m [3];
    int         last_coord [3];
    logic [2:0] lvl_m = 3'b000;

    function automatic int ref_coord(input int w);
        if (w <= MIN) return 0;
        if (w >= MAX) return 1023;
        return ((w - MIN) * 1023 + (MAX - MIN) / 2) / (MAX - MIN);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One clock of stimulus; the model tracks pulses in raw input terms.
    task automatic drive(input logic [2:0] lv, input bit r);
        int w;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        pwm = lv;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                armed_m[i]    = 1'b0;
                meas_m[i]     = 1'b0;
                fault_m[i]    = 1'b0;
                last_coord[i] = 0;
                last_edge[i]  = cyc - 2;
            end else begin
                if (lv[i] && !lvl_m[i]) begin
                    saved_edge[i] = last_edge[i];
                    last_edge[i]  = cyc + FILT;
                    meas_m[i]     = armed_m[i];
                    hi_start[i]   = cyc;
                end else if (!lv[i] && lvl_m[i]) begin
                    w = cyc - hi_start[i];
                    if (w >= FILT) begin
                        last_edge[i] = cyc + FILT;
                        if (meas_m[i]) begin
                            e.ch = i; e.coord = ref_coord(w); e.at = cyc + 4 + FILT;
                            sb_q.push_back(e);
                            last_coord[i] = e.coord;
                            fault_m[i]    = 1'b0;
                        end
                    end else begin
                        last_edge[i] = saved_edge[i];  // filtered glitch never happened
                    end
                    meas_m[i] = 1'b0;
                end
                if (!lv[i]) armed_m[i] = 1'b1;
                if (!fault_m[i] && (cyc - last_edge[i] == T + 3)) begin
                    e.ch = i; e.coord = 1; e.at = cyc;
                    flt_q.push_back(e);
                    fault_m[i] = 1'b1;
                end
            end
        end
        lvl_m = lv;
    endtask

    task automatic hold(input logic [2:0] lv, input int n);
        for (int k = 0; k < n; k++) drive(lv, 1'b0);
    endtask

    task automatic frame(input int w0, input int w1, input int w2,
                         input int s0, input int s1, input int s2, input int gap);
        int ws [3];
        int ss [3];
        int len;
        logic [2:0] lv;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        ss[0] = s0; ss[1] = s1; ss[2] = s2;
        len = 0;
        for (int i = 0; i < 3; i++) if (ss[i] + ws[i] > len) len = ss[i] + ws[i];
        len += gap;
        for (int c = 0; c < len; c++) begin
            for (int i = 0; i < 3; i++) lv[i] = (ws[i] > 0) && (c >= ss[i]) && (c < ss[i] + ws[i]);
            drive(lv, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes valid or raises fault.
    initial begin
        logic [2:0] fault_prev;
        logic [9:0] c;
        int idx;
        exp_t e;
        fault_prev = 3'b000;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                c = (i == 0) ? x : (i == 1) ? y : z;
                if (valid[i] === 1'b1) begin
                    idx = -1;
                    foreach (sb_q[k]) if (idx < 0 && sb_q[k].ch == i) idx = k;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_valid_ch%0d", i), 1, 0);
                    end else begin
                        e = sb_q[idx];
                        sb_q.delete(idx);
                        chk($sformatf("coord_ch%0d", i), int'(c), e.coord);
                        chk($sformatf("latency_ch%0d", i), cyc, e.at);
                        chk($sformatf("fault_clear_ch%0d", i), int'(fault[i]), 0);
                    end
                end
                if (fault[i] === 1'b1 && !fault_prev[i]) begin
                    idx = -1;
                    foreach (flt_q[k]) if (idx < 0 && flt_q[k].ch == i) idx = k;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_fault_ch%0d", i), 1, 0);
                    end else begin
                        e = flt_q[idx];
                        flt_q.delete(idx);
                        chk($sformatf("fault_time_ch%0d", i), cyc, e.at);
                    end
                end
            end
            fault_prev = (fault === 3'bxxx) ? 3'b000 : fault;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wmin;
        for (int i = 0; i < 3; i++) begin
            armed_m[i] = 0; meas_m[i] = 0; hi_start[i] = 0; last_edge[i] = 0;
            saved_edge[i] = 0; fault_m[i] = 0; last_coord[i] = 0;
        end
        wmin = (FILT > 0) ? FILT + 2 : 1;

        // Reset state
        repeat (5) drive(3'b000, 1'b1);
        hold(3'b000, 10);
        chk("reset_x", int'(x), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_z", int'(z), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_fault", int'(fault), 0);

        // Full-scale pulses on all channels
        repeat (3) frame(125, 125, 125, 0, 0, 0, 100);
        chk("full_x", int'(x), 1023);
        chk("full_y", int'(y), 1023);
        chk("full_z", int'(z), 1023);

        // Lower clamp, midpoint rounding
        frame(25, 75, 10, 0, 0, 0, 60);
        hold(3'b000, 10);
        chk("mid_x", int'(x), 0);
        chk("mid_y", int'(y), 512);
        chk("mid_z", int'(z), 0);

        // Randomized staggered frames
        for (int f = 0; f < 20; f++)
            frame($urandom_range(160, wmin), $urandom_range(160, wmin), $urandom_range(160, wmin),
                  $urandom_range(20, 0), $urandom_range(20, 0), $urandom_range(20, 0),
                  $urandom_range(60, 20));

        // Channel 2 goes silent long enough to time out
        repeat (3) frame(100, 0, 100, 0, 0, 0, 60);
        chk("timeout_fault", int'(fault), 3'b010);
        chk("timeout_y_hold", int'(y), last_coord[1]);
        frame(100, 100, 100, 0, 0, 0, 60);
        chk("recover_y", int'(y), 767);
        chk("recover_fault", int'(fault), 0);

        // Short glitches in the low phase
        frame(60, 60, 60, 0, 0, 0, 20);
        hold(3'b111, 5);
        hold(3'b000, 40);
        chk("glitch_x", int'(x), (FILT > 0) ? ref_coord(60) : 0);
        chk("glitch_z", int'(z), (FILT > 0) ? ref_coord(60) : 0);

        // Input high across reset release: partial pulse not measured
        hold(3'b111, 20);
        repeat (5) drive(3'b111, 1'b1);
        hold(3'b111, 30);
        hold(3'b000, 40);
        chk("partial_x", int'(x), 0);
        chk("partial_y", int'(y), 0);
        frame(80, 90, 100, 0, 0, 0, 60);
        chk("after_partial_z", int'(z), ref_coord(100));

        // Reset in the middle of a pulse, then over-range pulses
        hold(3'b111, 50);
        repeat (3) drive(3'b111, 1'b1);
        hold(3'b111, 20);
        hold(3'b000, 40);
        chk("abort_x", int'(x), 0);
        chk("abort_valid", int'(valid), 0);
        repeat (2) frame(200, 200, 200, 0, 0, 0, 60);
        chk("over_x", int'(x), 1023);
        chk("over_y", int'(y), 1023);

        hold(3'b000, 20);
        chk("sb_drain", sb_q.size(), 0);
        chk("fault_drain", flt_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
